// File: rtl/pipe_defs.sv
// Shared IF-stage definitions: widths, reset PC, PC step
// and the fetch sequencer state encodings.
package pipe_defs;

  localparam int PC_W     = 6;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;
  localparam int PC_STEP  = 2;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used to count taken redirects.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: step up unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC sequencer: owns the PC, drives the instruction
// memory address/flush and tags returned words with PC/valid.
module fetch_sequencer #(
  parameter int PC_W     = pipe_defs::PC_W,
  parameter int INSTR_W  = pipe_defs::INSTR_W,
  parameter int RESET_PC = pipe_defs::RESET_PC,
  parameter int PC_STEP  = pipe_defs::PC_STEP
) (
  input  logic               CLOCK,
  input  logic               in_rst_n,
  input  logic               in_stall,
  input  logic               in_br_taken,
  input  logic [PC_W-1:0]    in_br_target,
  input  logic [INSTR_W-1:0] in_instrn,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_mem_flush,
  output logic [INSTR_W-1:0] out_if_instrn,
  output logic [PC_W-1:0]    out_if_pc,
  output logic               out_if_valid,
  output logic [7:0]         out_redirects
);

  import pipe_defs::*;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] if_pc_d;
  logic            if_valid_d;
  logic            flush_d;
  logic            redir_inc;

  // next-state: branch beats stall beats sequential advance
  always_comb begin
    state_d    = state_q;
    pc_d       = out_pc;
    if_pc_d    = out_if_pc;
    if_valid_d = out_if_valid;
    redir_inc  = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d    = S_RUN;
        pc_d       = PC_W'(RESET_PC);
        if_valid_d = 1'b0;
      end
      S_RUN, S_REDIR: begin
        if (in_br_taken) begin
          state_d    = S_REDIR;
          pc_d       = in_br_target;
          if_valid_d = 1'b0;
          redir_inc  = 1'b1;
        end else if (in_stall) begin
          if (state_q == S_REDIR) begin
            if_valid_d = 1'b0;
          end
        end else begin
          state_d    = S_RUN;
          if_pc_d    = out_pc;
          if_valid_d = 1'b1;
          pc_d       = out_pc + PC_W'(PC_STEP);
        end
      end
      default: begin
        state_d    = S_INIT;
        pc_d       = PC_W'(RESET_PC);
        if_valid_d = 1'b0;
      end
    endcase
    flush_d = (state_d != S_RUN);
  end

  // state and IF output registers, synchronous reset
  always_ff @(posedge CLOCK) begin
    if (!in_rst_n) begin
      state_q       <= S_INIT;
      out_pc        <= PC_W'(RESET_PC);
      out_if_pc     <= '0;
      out_if_valid  <= 1'b0;
      out_mem_flush <= 1'b1;
    end else begin
      state_q       <= state_d;
      out_pc        <= pc_d;
      out_if_pc     <= if_pc_d;
      out_if_valid  <= if_valid_d;
      out_mem_flush <= flush_d;
    end
  end

  sat_counter #(
    .W(8)
  ) u_redir_cnt (
    .clk_i  (CLOCK),
    .rst_n_i(in_rst_n),
    .inc_i  (redir_inc),
    .cnt_o  (out_redirects)
  );

  assign out_if_instrn = in_instrn;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural
// instruction memory and a reference model of the PC rules.
module tb_fetch_sequencer;

  logic        CLOCK = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_stall = 1'b0;
  logic        in_br_taken = 1'b0;
  logic [5:0]  in_br_target = '0;
  logic [15:0] in_instrn;
  logic [5:0]  out_pc;
  logic        out_mem_flush;
  logic [15:0] out_if_instrn;
  logic [5:0]  out_if_pc;
  logic        out_if_valid;
  logic [7:0]  out_redirects;

  always #20 CLOCK = ~CLOCK;

  fetch_sequencer dut (
    .CLOCK        (CLOCK),
    .in_rst_n     (in_rst_n),
    .in_stall     (in_stall),
    .in_br_taken  (in_br_taken),
    .in_br_target (in_br_target),
    .in_instrn    (in_instrn),
    .out_pc       (out_pc),
    .out_mem_flush(out_mem_flush),
    .out_if_instrn(out_if_instrn),
    .out_if_pc    (out_if_pc),
    .out_if_valid (out_if_valid),
    .out_redirects(out_redirects)
  );

  logic [15:0] mem [32];
  logic [15:0] mem_q;

  always @(posedge CLOCK) mem_q <= mem[out_pc[5:1]];
  assign in_instrn = mem_q;

  typedef struct packed {
    logic [5:0] pc;
    logic [5:0] ifpc;
    logic       valid;
    logic       flush;
    logic [7:0] cnt;
    logic       chk_word;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  bit       m_init, m_redir, m_valid, m_flush;
  int       m_pc, m_ifpc, m_cnt;

  task automatic step(input bit rst_n, input bit stall,
                      input bit br, input logic [5:0] tgt);
    exp_t e;
    bit   adv;
    @(negedge CLOCK);
    in_rst_n = rst_n;
    in_stall = stall;
    in_br_taken = br;
    in_br_target = tgt;
    adv = 0;
    if (!rst_n) begin
      m_init = 1; m_redir = 0; m_pc = 0; m_ifpc = 0;
      m_valid = 0; m_flush = 1; m_cnt = 0;
    end else if (m_init) begin
      m_init = 0; m_pc = 0; m_valid = 0; m_flush = 0;
    end else if (br) begin
      m_pc = tgt; m_valid = 0; m_redir = 1; m_flush = 1;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end else if (stall) begin
      if (m_redir) m_valid = 0;
    end else begin
      m_ifpc = m_pc; m_valid = 1; adv = 1;
      m_pc = (m_pc + 2) % 64;
      m_redir = 0; m_flush = 0;
    end
    e.pc = 6'(m_pc);
    e.ifpc = 6'(m_ifpc);
    e.valid = m_valid;
    e.flush = m_flush;
    e.cnt = 8'(m_cnt);
    e.chk_word = adv;
    q.push_back(e);
  endtask

  // monitor: compare each cycle's outputs against the queue head
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge CLOCK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {out_pc, out_if_pc, out_if_valid, out_mem_flush,
             out_redirects, e.chk_word};
        checks++;
        if (g != e) begin
          failures++;
          $display("FAIL state: got pc=%0d ifpc=%0d v=%0b fl=%0b cnt=%0d exp pc=%0d ifpc=%0d v=%0b fl=%0b cnt=%0d",
                   out_pc, out_if_pc, out_if_valid, out_mem_flush,
                   out_redirects, e.pc, e.ifpc, e.valid, e.flush, e.cnt);
        end
        checks++;
        if (out_if_instrn !== mem_q) begin
          failures++;
          $display("FAIL passthru: got %h exp %h", out_if_instrn, mem_q);
        end
        if (e.chk_word) begin
          checks++;
          if (out_if_instrn !== mem[e.ifpc[5:1]]) begin
            failures++;
            $display("FAIL word@%0d: got %h exp %h", e.ifpc,
                     out_if_instrn, mem[e.ifpc[5:1]]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    // reset then sequential fetch
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    // stall 3 cycles at pc 8
    n = 0;
    while (m_pc != 8 && n < 40) begin step(1, 0, 0, 0); n++; end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // single redirect at pc 4 to 8
    step(0, 0, 0, 0);
    n = 0;
    while (m_pc != 4 && n < 40) begin step(1, 0, 0, 0); n++; end
    step(1, 0, 1, 6'b001000);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // back-to-back redirects
    step(1, 0, 1, 6'd16);
    step(1, 0, 1, 6'd32);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // wrap from 62
    n = 0;
    while (m_pc != 62 && n < 40) begin step(1, 0, 0, 0); n++; end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // branch during stall, then reset in stalled redirect
    step(1, 1, 1, 6'd20);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // 300 redirects to reach saturation
    for (int i = 0; i < 300; i++)
      step(1, $urandom_range(0, 1), 1, 6'($urandom));
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 6'($urandom));
    step(1, 0, 0, 0);
    @(posedge CLOCK);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
